// File: rtl/puf_response_voter.sv
// Majority voter that turns NUM_SAMPLES noisy PUF captures into a stable 64-bit key.
// Optional macro PUF_STABILITY_CHECK_EN adds the unstable_count output.
module puf_response_voter #(
  parameter int unsigned NUM_SAMPLES   = 7,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  challenge,
  input  logic [63:0] puf_response,
  output logic        puf_enable,
  output logic [1:0]  puf_control,
  output logic [63:0] key,
  output logic        key_valid,
`ifdef PUF_STABILITY_CHECK_EN
  output logic [6:0]  unstable_count,
`endif
  output logic        busy
);

  localparam int unsigned KEY_W    = 64;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned SETTLE_W = 4;
  localparam int unsigned SAMPLE_W = 4;
  localparam int unsigned HALF     = NUM_SAMPLES / 2;

  typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DONE} state_t;

  state_t              state_q, state_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic [CNT_W-1:0]    cnt_q [KEY_W];
  logic [CNT_W-1:0]    tally [KEY_W];
  logic                clr, cap;
  logic [1:0]          ctrl_d;
  logic [KEY_W-1:0]    key_d;
`ifdef PUF_STABILITY_CHECK_EN
  logic [6:0]          unst_d;
`endif

  // Next state, counter control and next values of the registered outputs
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    sample_d = sample_q;
    ctrl_d   = puf_control;
    key_d    = key;
    clr      = 1'b0;
    cap      = 1'b0;
`ifdef PUF_STABILITY_CHECK_EN
    unst_d   = unstable_count;
`endif
    // tally includes the response being captured this cycle, so DONE sees the final vote
    for (int i = 0; i < KEY_W; i++) begin
      tally[i] = cnt_q[i] + CNT_W'(puf_response[i]);
    end
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = ARM;
          ctrl_d   = challenge;
          clr      = 1'b1;
          settle_d = '0;
          sample_d = '0;
        end
      end
      ARM: begin
        settle_d = settle_q + SETTLE_W'(1);
        if (settle_q == SETTLE_W'(SETTLE_CYCLES - 1)) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        cap      = 1'b1;
        settle_d = '0;
        sample_d = sample_q + SAMPLE_W'(1);
        if (sample_q == SAMPLE_W'(NUM_SAMPLES - 1)) begin
          state_d = DONE;
          for (int i = 0; i < KEY_W; i++) begin
            key_d[i] = (tally[i] > CNT_W'(HALF));
          end
`ifdef PUF_STABILITY_CHECK_EN
          unst_d = '0;
          for (int i = 0; i < KEY_W; i++) begin
            if ((tally[i] != '0) && (tally[i] != CNT_W'(NUM_SAMPLES))) begin
              unst_d = unst_d + 7'd1;
            end
          end
`endif
        end else begin
          state_d = ARM;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      settle_q    <= '0;
      sample_q    <= '0;
      puf_enable  <= 1'b0;
      puf_control <= 2'b00;
      key         <= '0;
      key_valid   <= 1'b0;
      busy        <= 1'b0;
`ifdef PUF_STABILITY_CHECK_EN
      unstable_count <= '0;
`endif
      for (int i = 0; i < KEY_W; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      sample_q    <= sample_d;
      puf_enable  <= (state_d == ARM);
      puf_control <= ctrl_d;
      key         <= key_d;
      key_valid   <= (state_d == DONE);
      busy        <= (state_d != IDLE);
`ifdef PUF_STABILITY_CHECK_EN
      unstable_count <= unst_d;
`endif
      for (int i = 0; i < KEY_W; i++) begin
        if (clr) begin
          cnt_q[i] <= '0;
        end else if (cap) begin
          cnt_q[i] <= tally[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_puf_response_voter.sv
// Self-checking bench for puf_response_voter: cycle-level reference model plus directed cases.
// Honours PUF_STABILITY_CHECK_EN when defined.
module tb_puf_response_voter;

  localparam int N = 7;
  localparam int S = 4;
  localparam int P = S + 1;
  localparam int L = N * P + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  challenge = 2'b00;
  logic [63:0] puf_response = '0;
  logic        puf_enable, key_valid, busy;
  logic [1:0]  puf_control;
  logic [63:0] key;
`ifdef PUF_STABILITY_CHECK_EN
  logic [6:0]  unstable_count;
  logic [6:0]  s_unstable_count;
`endif

  logic        s_start = 1'b0;
  logic [63:0] s_response = '0;
  logic        s_puf_enable, s_key_valid, s_busy;
  logic [1:0]  s_puf_control;
  logic [63:0] s_key;

  int total = 0;
  int bad = 0;

  // model state: cycles since accepted start and per-bit count of ones
  bit          m_busy;
  int          m_c;
  logic [1:0]  m_ctrl;
  logic [63:0] m_key;
  int          m_unst;
  int          ones [64];
  logic        obs_kv;

  always #5 clk = ~clk;

  puf_response_voter dut (
    .clk(clk), .rst(rst), .start(start), .challenge(challenge),
    .puf_response(puf_response), .puf_enable(puf_enable), .puf_control(puf_control),
    .key(key), .key_valid(key_valid),
`ifdef PUF_STABILITY_CHECK_EN
    .unstable_count(unstable_count),
`endif
    .busy(busy)
  );

  puf_response_voter #(.NUM_SAMPLES(3), .SETTLE_CYCLES(1)) u_small (
    .clk(clk), .rst(rst), .start(s_start), .challenge(2'b11),
    .puf_response(s_response), .puf_enable(s_puf_enable), .puf_control(s_puf_control),
    .key(s_key), .key_valid(s_key_valid),
`ifdef PUF_STABILITY_CHECK_EN
    .unstable_count(s_unstable_count),
`endif
    .busy(s_busy)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_c = 0; m_ctrl = 2'b00; m_key = '0; m_unst = 0;
    foreach (ones[i]) ones[i] = 0;
  endtask

  // Advance the model across the coming rising edge using the inputs just driven
  task automatic model_step();
    if (rst) begin
      model_reset();
    end else if (!m_busy) begin
      if (start) begin
        m_busy = 1'b1; m_c = 1; m_ctrl = challenge;
        foreach (ones[i]) ones[i] = 0;
      end
    end else begin
      if (m_c < L && m_c % P == 0)
        foreach (ones[i]) ones[i] += int'(puf_response[i]);
      if (m_c == L) begin
        m_busy = 1'b0;
      end else begin
        m_c++;
        if (m_c == L) begin
          m_unst = 0;
          foreach (ones[i]) begin
            m_key[i] = (ones[i] * 2 > N);
            if (ones[i] != 0 && ones[i] != N) m_unst++;
          end
        end
      end
    end
  endtask

  // One cycle: compare outputs mid-cycle, then drive inputs for this cycle
  task automatic tick(input logic r, input logic s, input logic [1:0] ch, input logic [63:0] rv);
    @(negedge clk);
    chk("puf_enable", 64'(puf_enable), 64'(m_busy && m_c < L && m_c % P != 0));
    chk("key_valid", 64'(key_valid), 64'(m_busy && m_c == L));
    chk("busy", 64'(busy), 64'(m_busy));
    chk("puf_control", 64'(puf_control), 64'(m_ctrl));
    chk("key", key, m_key);
`ifdef PUF_STABILITY_CHECK_EN
    chk("unstable_count", 64'(unstable_count), 64'(m_unst));
`endif
    obs_kv = key_valid;
    rst = r; start = s; challenge = ch; puf_response = rv;
    model_step();
  endtask

  function automatic logic [63:0] sample_for(input int kind, input int k);
    case (kind)
      0: return 64'hA5A5_5A5A_0F0F_F0F0;
      1: return (k < 3) ? 64'h1 : 64'h0;
      2: return (k % 2 == 0) ? 64'h8000_0000_0000_0000 : 64'h0;
      default: return rand64();
    endcase
  endfunction

  task automatic check_reset_values(input string tag);
    chk({tag, "_enable"}, 64'(puf_enable), 64'h0);
    chk({tag, "_control"}, 64'(puf_control), 64'h0);
    chk({tag, "_key"}, key, 64'h0);
    chk({tag, "_valid"}, 64'(key_valid), 64'h0);
    chk({tag, "_busy"}, 64'(busy), 64'h0);
`ifdef PUF_STABILITY_CHECK_EN
    chk({tag, "_unstable"}, 64'(unstable_count), 64'h0);
`endif
  endtask

  // One key generation; optional start/challenge poke mid-run and optional reset
  task automatic run_key(input logic [1:0] ch, input int kind, input int poke, input int rst_at,
                         output int kv_at, output int kv_n);
    logic s;
    logic [1:0] chv;
    logic [63:0] rv;
    kv_at = -1; kv_n = 0;
    tick(1'b0, 1'b1, ch, rand64());
    for (int c = 1; c <= L; c++) begin
      s   = (kind == 3) ? ($urandom_range(0, 3) == 0) : 1'b0;
      chv = 2'($urandom);
      rv  = (c % P == 0) ? sample_for(kind, c / P - 1) : rand64();
      if (c == poke) begin s = 1'b1; chv = 2'b01; end
      tick(1'b0, s, chv, rv);
      if (obs_kv) begin kv_n++; kv_at = c; end
      if (c == rst_at) begin
        #2 rst = 1'b1;
        model_reset();
        #1 check_reset_values("async_rst");
        return;
      end
    end
  endtask

  initial begin
    int kv_at, kv_n;
    logic [5:0] pat;
    model_reset();
    tick(1'b1, 1'b0, 2'b00, '0);
    tick(1'b1, 1'b0, 2'b00, '0);
    check_reset_values("reset");
    tick(1'b0, 1'b0, 2'b00, '0);

    // constant response must vote back to itself, latency pinned
    run_key(2'b00, 0, 0, 0, kv_at, kv_n);
    chk("const_key", key, 64'hA5A5_5A5A_0F0F_F0F0);
    chk("const_latency", 64'(kv_at), 64'd36);
    chk("const_pulses", 64'(kv_n), 64'd1);
`ifdef PUF_STABILITY_CHECK_EN
    chk("const_unstable", 64'(unstable_count), 64'd0);
`endif
    repeat (3) tick(1'b0, 1'b0, 2'($urandom), rand64());

    run_key(2'b01, 1, 0, 0, kv_at, kv_n);
    chk("bit0_3of7_key", key, 64'h0);
`ifdef PUF_STABILITY_CHECK_EN
    chk("bit0_unstable", 64'(unstable_count), 64'd1);
`endif
    repeat (2) tick(1'b0, 1'b0, 2'($urandom), rand64());

    run_key(2'b11, 2, 0, 0, kv_at, kv_n);
    chk("bit63_4of7_key", key, 64'h8000_0000_0000_0000);
    repeat (4) tick(1'b0, 1'b0, 2'($urandom), rand64());
    chk("key_holds", key, 64'h8000_0000_0000_0000);

    // challenge change and start while busy are ignored
    run_key(2'b10, 4, 10, 0, kv_at, kv_n);
    chk("busy_challenge", 64'(puf_control), 64'h2);
    repeat (5) begin
      tick(1'b0, 1'b0, 2'b01, rand64());
      if (obs_kv) kv_n++;
    end
    chk("busy_start_pulses", 64'(kv_n), 64'd1);
    chk("busy_start_latency", 64'(kv_at), 64'd36);

    // back-to-back random runs, start also asserted in DONE
    for (int r = 0; r < 8; r++) begin
      run_key(2'($urandom), 3, 0, 0, kv_at, kv_n);
    end
    repeat (3) tick(1'b0, 1'b0, 2'($urandom), rand64());

    // reset mid-run discards the vote
    run_key(2'b11, 3, 0, 20, kv_at, kv_n);
    tick(1'b1, 1'b0, 2'b11, rand64());
    tick(1'b0, 1'b0, 2'b11, rand64());
    kv_n = 0;
    repeat (60) begin
      tick(1'b0, 1'b0, 2'($urandom), rand64());
      if (obs_kv) kv_n++;
    end
    chk("post_reset_pulses", 64'(kv_n), 64'd0);

    // small instance: enable pattern and latency
    pat = 6'b101010;
    @(negedge clk);
    s_start = 1'b1; s_response = '1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      s_start = 1'b0;
      if (c <= 6) chk("small_enable", 64'(s_puf_enable), 64'(pat[6 - c]));
      chk("small_valid", 64'(s_key_valid), 64'(c == 7));
    end
    chk("small_key", s_key, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("small_control", 64'(s_puf_control), 64'h3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
